// File: rtl/cordic_nco_phase_if.sv
// Control and angle-output bundle between the NCO phase generator and its consumer.
// The master drives frequency/offset/sync controls; the slave returns angle, ce and freq_ack.
interface cordic_nco_phase_if #(
    parameter int unsigned FW = 20
);
    logic [FW-1:0] freq_word;
    logic          freq_load;
    logic [11:0]   phase_offset;
    logic          sync_clear;
    logic [11:0]   angle;
    logic          ce;
    logic          freq_ack;

    modport master (
        output freq_word,
        output freq_load,
        output phase_offset,
        output sync_clear,
        input  angle,
        input  ce,
        input  freq_ack
    );

    modport slave (
        input  freq_word,
        input  freq_load,
        input  phase_offset,
        input  sync_clear,
        output angle,
        output ce,
        output freq_ack
    );
endinterface

// File: rtl/cordic_nco_phase.sv
// Fractional phase accumulator wrapping modulo PHASE_MOD angle codes, producing a registered
// angle plus ce strobe for cordic_360; frequency changes take effect at an accumulator wrap.
module cordic_nco_phase #(
    parameter int unsigned PHASE_MOD = 3212,
    parameter int unsigned FRAC      = 8,
    parameter int unsigned FW        = 20,
    parameter int unsigned STEP_DIV  = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    cordic_nco_phase_if.slave    bus
);
    localparam int unsigned AccW = 12 + FRAC;
    localparam int unsigned SumW = ((AccW > FW) ? AccW : FW) + 1;
    localparam int unsigned CntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [SumW-1:0] FullS   = SumW'(PHASE_MOD) << FRAC;
    localparam logic [FW-1:0]   FreqMax = FW'(FullS - SumW'(1));
    localparam logic [12:0]     ModA    = 13'(PHASE_MOD);
    localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);

    logic [AccW-1:0] acc_q, acc_d;
    logic [FW-1:0]   f_act_q, f_act_d;
    logic [FW-1:0]   f_pend_q, f_pend_d;
    logic            pend_valid_q, pend_valid_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [11:0]     angle_q, angle_d;
    logic            ce_q, ce_d;
    logic            ack_q, ack_d;

    logic            tick;
    logic            wrap;
    logic            apply_ok;
    logic [FW-1:0]   freq_clamp;
    logic [12:0]     off_ext;
    logic [11:0]     off_red;
    logic [12:0]     ang_sum;
    logic [11:0]     ang_next;
    logic [SumW-1:0] sum;
    logic [AccW-1:0] acc_step;

    // Input conditioning: out-of-range words saturate, offsets fold back once.
    always_comb begin
        freq_clamp = (SumW'(bus.freq_word) >= FullS) ? FreqMax : bus.freq_word;
        off_ext    = {1'b0, bus.phase_offset};
        off_red    = (off_ext >= ModA) ? 12'(off_ext - ModA) : bus.phase_offset;
    end

    always_comb begin
        tick     = (cnt_q == CntLast);
        ang_sum  = {1'b0, acc_q[AccW-1:FRAC]} + {1'b0, off_red};
        ang_next = (ang_sum >= ModA) ? 12'(ang_sum - ModA) : ang_sum[11:0];
        sum      = SumW'(acc_q) + SumW'(f_act_q);
        wrap     = (sum >= FullS);
        acc_step = wrap ? AccW'(sum - FullS) : AccW'(sum);
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        angle_d      = angle_q;
        f_act_d      = f_act_q;
        f_pend_d     = f_pend_q;
        pend_valid_d = pend_valid_q;
        ce_d         = 1'b0;
        ack_d        = 1'b0;
        apply_ok     = (f_act_q == '0);

        if (bus.sync_clear) begin
            acc_d    = '0;
            cnt_d    = '0;
            apply_ok = 1'b1;
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                angle_d = ang_next;
                ce_d    = 1'b1;
                acc_d   = acc_step;
                if (wrap) begin
                    apply_ok = 1'b1;
                end
            end
        end

        // A load coinciding with an apply waits in f_pend for the next apply point.
        if (pend_valid_q && apply_ok) begin
            f_act_d      = f_pend_q;
            pend_valid_d = 1'b0;
            ack_d        = 1'b1;
            if (bus.freq_load) begin
                f_pend_d     = freq_clamp;
                pend_valid_d = 1'b1;
            end
        end else if (bus.freq_load) begin
            f_pend_d = freq_clamp;
            if (f_act_q == '0) begin
                f_act_d = freq_clamp;
                ack_d   = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            acc_q        <= '0;
            f_act_q      <= '0;
            f_pend_q     <= '0;
            pend_valid_q <= 1'b0;
            cnt_q        <= '0;
            angle_q      <= '0;
            ce_q         <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            f_act_q      <= f_act_d;
            f_pend_q     <= f_pend_d;
            pend_valid_q <= pend_valid_d;
            cnt_q        <= cnt_d;
            angle_q      <= angle_d;
            ce_q         <= ce_d;
            ack_q        <= ack_d;
        end
    end

    assign bus.angle    = angle_q;
    assign bus.ce       = ce_q;
    assign bus.freq_ack = ack_q;

endmodule

// File: tb/tb_cordic_nco_phase.sv
// Self-checking bench: two instances (STEP_DIV 1 and 4) share stimulus and are compared
// against an arithmetic reference model, plus directed tables and corner sequences.
module tb_cordic_nco_phase;
    localparam int PM   = 3212;
    localparam int FULL = PM * 256;

    logic clock;
    logic reset;

    cordic_nco_phase_if #(.FW(20)) if1 ();
    cordic_nco_phase_if #(.FW(20)) if4 ();

    assign if4.freq_word    = if1.freq_word;
    assign if4.freq_load    = if1.freq_load;
    assign if4.phase_offset = if1.phase_offset;
    assign if4.sync_clear   = if1.sync_clear;

    cordic_nco_phase #(.PHASE_MOD(3212), .FRAC(8), .FW(20), .STEP_DIV(1)) dut1 (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (if1)
    );

    cordic_nco_phase #(.PHASE_MOD(3212), .FRAC(8), .FW(20), .STEP_DIV(4)) dut4 (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (if4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int acc;
        int fact;
        int fpend;
        bit pv;
        int cnt;
        int angle;
        bit ce;
        bit ack;
    } mst_t;

    typedef struct {
        bit fl;
        int fw;
        int angle;
        bit ce;
        bit ack;
    } vec_t;

    mst_t m1, m4;
    int   checks = 0;
    int   errors = 0;

    // Reference: one clock of the NCO described with plain modular arithmetic.
    function automatic mst_t mstep(mst_t s, int div, bit rst, int fw, bit fl, int off, bit sc);
        mst_t n;
        int   fwc, offr;
        bit   tick, wrap, can_apply;
        n = s;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        n.ce  = 0;
        n.ack = 0;
        fwc   = (fw >= FULL) ? FULL - 1 : fw;
        offr  = (off >= PM) ? off - PM : off;
        tick  = (s.cnt == div - 1);
        wrap  = 0;
        if (sc) begin
            n.acc = 0;
            n.cnt = 0;
        end else begin
            n.cnt = (s.cnt + 1) % div;
            if (tick) begin
                n.ce    = 1;
                n.angle = (s.acc / 256 + offr) % PM;
                wrap    = (s.acc + s.fact >= FULL);
                n.acc   = (s.acc + s.fact) % FULL;
            end
        end
        can_apply = sc || wrap || (s.fact == 0);
        if (s.pv && can_apply) begin
            n.fact = s.fpend;
            n.pv   = 0;
            n.ack  = 1;
        end
        if (fl) begin
            if (s.fact == 0 && !s.pv) begin
                n.fact = fwc;
                n.ack  = 1;
            end else begin
                n.fpend = fwc;
                n.pv    = 1;
            end
        end
        return n;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(bit rst, int fw, bit fl, int off, bit sc);
        reset            = rst;
        if1.freq_word    = 20'(fw);
        if1.freq_load    = fl;
        if1.phase_offset = 12'(off);
        if1.sync_clear   = sc;
        @(posedge clock);
        #1;
        m1 = mstep(m1, 1, rst, fw, fl, off, sc);
        m4 = mstep(m4, 4, rst, fw, fl, off, sc);
        chk("d1.angle", int'(if1.angle), m1.angle);
        chk("d1.ce", int'(if1.ce), int'(m1.ce));
        chk("d1.ack", int'(if1.freq_ack), int'(m1.ack));
        chk("d4.angle", int'(if4.angle), m4.angle);
        chk("d4.ce", int'(if4.ce), int'(m4.ce));
        chk("d4.ack", int'(if4.freq_ack), int'(m4.ack));
    endtask

    vec_t sweep[7];
    int   prev, stp, ce_cnt, consec, last_ce, stable_bad;

    initial begin
        sweep[0] = '{fl: 1, fw: 205568, angle: 0,    ce: 1, ack: 1};
        sweep[1] = '{fl: 0, fw: 0,      angle: 0,    ce: 1, ack: 0};
        sweep[2] = '{fl: 0, fw: 0,      angle: 803,  ce: 1, ack: 0};
        sweep[3] = '{fl: 0, fw: 0,      angle: 1606, ce: 1, ack: 0};
        sweep[4] = '{fl: 0, fw: 0,      angle: 2409, ce: 1, ack: 0};
        sweep[5] = '{fl: 0, fw: 0,      angle: 0,    ce: 1, ack: 0};
        sweep[6] = '{fl: 0, fw: 0,      angle: 803,  ce: 1, ack: 0};

        m1 = '{default: 0};
        m4 = '{default: 0};
        reset = 1'b1;
        if1.freq_word = '0;
        if1.freq_load = 1'b0;
        if1.phase_offset = '0;
        if1.sync_clear = 1'b0;

        // Reset state
        repeat (3) cycle(1, 0, 0, 0, 0);
        chk("rst.angle", int'(if1.angle), 0);
        chk("rst.ce", int'(if1.ce), 0);
        chk("rst.ack", int'(if1.freq_ack), 0);

        // Basic sweep table
        for (int i = 0; i < 7; i++) begin
            cycle(0, sweep[i].fw, sweep[i].fl, 0, 0);
            chk("sweep.angle", int'(if1.angle), sweep[i].angle);
            chk("sweep.ce", int'(if1.ce), int'(sweep[i].ce));
            chk("sweep.ack", int'(if1.freq_ack), int'(sweep[i].ack));
        end

        // Fractional increment: 0.5 code per tick returns to exactly zero after 6424 ticks
        cycle(1, 0, 0, 0, 0);
        cycle(0, 128, 1, 0, 0);
        for (int i = 0; i < 6424; i++) cycle(0, 0, 0, 0, 0);
        chk("frac.acc", int'(dut1.acc_q), 0);
        cycle(0, 0, 0, 0, 0);
        chk("frac.angle", int'(if1.angle), 0);

        // Phase-continuous update: ack only on the wrapping tick
        cycle(1, 0, 0, 0, 0);
        cycle(0, 205568, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 102784, 1, 0, 0);
        chk("cont.noack", int'(if1.freq_ack), 0);
        cycle(0, 0, 0, 0, 0);
        chk("cont.ack", int'(if1.freq_ack), 1);
        chk("cont.prewrap", int'(if1.angle), 2409);
        cycle(0, 0, 0, 0, 0);
        prev = int'(if1.angle);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 0, 0, 0);
            stp = (int'(if1.angle) - prev + PM) % PM;
            chk("cont.step", int'(stp == 401 || stp == 402), 1);
            prev = int'(if1.angle);
        end

        // Offset 3000 folds 803 + 3000 to 591
        cycle(1, 0, 0, 0, 0);
        cycle(0, 205568, 1, 3000, 0);
        chk("off.first", int'(if1.angle), 3000);
        cycle(0, 0, 0, 3000, 0);
        cycle(0, 0, 0, 3000, 0);
        chk("off.fold", int'(if1.angle), 591);

        // Frequency clamp: 0xFFFFF behaves as 822271
        cycle(1, 0, 0, 0, 0);
        cycle(0, 20'hFFFFF, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("clamp.angle", int'(if1.angle), 3211);

        // sync_clear while a word is pending, offset 4095 treated as 883
        cycle(1, 0, 0, 4095, 0);
        cycle(0, 205568, 1, 4095, 0);
        cycle(0, 0, 0, 4095, 0);
        cycle(0, 102784, 1, 4095, 0);
        chk("sync.pend_noack", int'(if1.freq_ack), 0);
        cycle(0, 0, 0, 4095, 1);
        chk("sync.ack", int'(if1.freq_ack), 1);
        chk("sync.ce", int'(if1.ce), 0);
        chk("sync.ce4", int'(if4.ce), 0);
        cycle(0, 0, 0, 4095, 0);
        chk("sync.first", int'(if1.angle), 883);
        chk("sync.firstce", int'(if1.ce), 1);
        cycle(0, 0, 0, 4095, 0);
        chk("sync.second", int'(if1.angle), 1284);

        // Divider: STEP_DIV=4 strobes once per four cycles, angle held between
        cycle(1, 0, 0, 0, 0);
        ce_cnt = 0; consec = 0; last_ce = 0; stable_bad = 0;
        prev = int'(if4.angle);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 205568, (i == 0), 0, 0);
            if (if4.ce) ce_cnt++;
            if (if4.ce && last_ce != 0) consec++;
            if (!if4.ce && int'(if4.angle) != prev) stable_bad++;
            last_ce = int'(if4.ce);
            prev = int'(if4.angle);
        end
        chk("div.count", ce_cnt, 10);
        chk("div.consec", consec, 0);
        chk("div.stable", stable_bad, 0);

        // Reset concurrent with freq_load
        cycle(1, 1000, 1, 0, 0);
        chk("rstld.angle", int'(if1.angle), 0);
        chk("rstld.ce", int'(if1.ce), 0);
        chk("rstld.ack", int'(if1.freq_ack), 0);
        cycle(0, 0, 0, 0, 0);
        chk("rstld.noack", int'(if1.freq_ack), 0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            int fw;
            fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1048575))
                                             : int'($urandom_range(0, 300000));
            cycle(($urandom_range(0, 199) == 0), fw, ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, 4095)), ($urandom_range(0, 79) == 0));
            chk("rand.range1", int'(if1.angle < 12'd3212), 1);
            chk("rand.range4", int'(if4.angle < 12'd3212), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
